// File: rtl/video_timing_pkg.sv
// Shared 720p60 timing defaults, coordinate/pixel types and colour bars.
// Consumed by the timing generator, its interface and downstream renderers.
package video_timing_pkg;

  localparam int H_RES = 1280;
  localparam int H_FP  = 110;
  localparam int H_SW  = 40;
  localparam int H_BP  = 220;
  localparam int V_RES = 720;
  localparam int V_FP  = 5;
  localparam int V_SW  = 5;
  localparam int V_BP  = 20;

  localparam logic SYNC_POL_DEF = 1'b1;

  typedef logic signed [11:0] coord_t;
  typedef logic [7:0][0:2] pixel_t;

  localparam pixel_t COLOUR_BARS [8] = '{
    24'hFFFFFF,
    24'hFFFF00,
    24'h00FFFF,
    24'h00FF00,
    24'hFF00FF,
    24'hFF0000,
    24'h0000FF,
    24'h000000
  };

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the timing generator to renderers/encoder.
// master drives, slave observes.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  coord_t hpos;
  coord_t vpos;
  logic   de;
  logic   hsync;
  logic   vsync;
  logic   fsync;
  pixel_t pattern;

  modport master (
    output hpos, vpos, de,
    output hsync, vsync, fsync,
    output pattern
  );

  modport slave (
    input hpos, vpos, de,
    input hsync, vsync, fsync,
    input pattern
  );

endinterface

// File: rtl/vtg_wrap_counter.sv
// Modulo (MAX+1) counter advancing on inc; tc flags the wrap cycle.
// Chained: the line counter's tc advances the frame counter.
module vtg_wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = inc && (cnt == W'(MAX));

  // count up on inc, wrap to zero at MAX
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (tc)  cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator (720p60 defaults), registered outputs.
// VIDEO_TIMING_GEN_TEST_PATTERN_EN enables the colour-bar pattern output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   HRES     = H_RES,
  parameter int   HFP      = H_FP,
  parameter int   HSW      = H_SW,
  parameter int   HBP      = H_BP,
  parameter int   VRES     = V_RES,
  parameter int   VFP      = V_FP,
  parameter int   VSW      = V_SW,
  parameter int   VBP      = V_BP,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic pixel_clk,
  input  logic rst,
  video_timing_gen_if.master vif
);

  localparam int HTOT = HRES + HFP + HSW + HBP;
  localparam int VTOT = VRES + VFP + VSW + VBP;

  if (HTOT - 1 > 2047 || VTOT - 1 > 2047) begin : g_bad_totals
    $error("video_timing_gen: totals exceed 12-bit signed range");
  end

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_tc;
  logic        v_tc_unused;

  vtg_wrap_counter #(.MAX(HTOT - 1), .W(12)) u_h_cnt (
    .clk (pixel_clk),
    .rst (rst),
    .inc (1'b1),
    .cnt (h_cnt),
    .tc  (h_tc)
  );

  vtg_wrap_counter #(.MAX(VTOT - 1), .W(12)) u_v_cnt (
    .clk (pixel_clk),
    .rst (rst),
    .inc (h_tc),
    .cnt (v_cnt),
    .tc  (v_tc_unused)
  );

  logic   de_n;
  logic   hs_n;
  logic   vs_n;
  logic   fs_n;
  pixel_t pat_n;

  assign de_n = (h_cnt < 12'(HRES)) && (v_cnt < 12'(VRES));
  assign hs_n = (h_cnt >= 12'(HRES + HFP)) &&
                (h_cnt <= 12'(HRES + HFP + HSW - 1));
  assign vs_n = (v_cnt >= 12'(VRES + VFP)) &&
                (v_cnt <= 12'(VRES + VFP + VSW - 1));
  assign fs_n = (h_cnt == 12'd0) && (v_cnt == 12'(VRES));

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  localparam int BAR_W = HRES / 8;

  logic [2:0] bar;

  // bar index = h_cnt / BAR_W, via threshold compares
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= 12'(k * BAR_W)) bar = 3'(k);
    end
  end

  assign pat_n = de_n ? COLOUR_BARS[bar] : '0;
`else
  assign pat_n = '0;
`endif

  // register every decode of the same counter pair together
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vif.hpos    <= '0;
      vif.vpos    <= '0;
      vif.de      <= 1'b0;
      vif.hsync   <= ~SYNC_POL;
      vif.vsync   <= ~SYNC_POL;
      vif.fsync   <= 1'b0;
      vif.pattern <= '0;
    end else begin
      vif.hpos    <= coord_t'(h_cnt);
      vif.vpos    <= coord_t'(v_cnt);
      vif.de      <= de_n;
      vif.hsync   <= hs_n ? SYNC_POL : ~SYNC_POL;
      vif.vsync   <= vs_n ? SYNC_POL : ~SYNC_POL;
      vif.fsync   <= fs_n;
      vif.pattern <= pat_n;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-parameter and default-parameter DUTs
// checked cycle by cycle against a queued reference plus event checks.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] pat;
  } obs_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  video_timing_gen_if sm_if ();
  video_timing_gen_if df_if ();

  video_timing_gen #(
    .HRES(16), .HFP(2), .HSW(3), .HBP(3),
    .VRES(8), .VFP(1), .VSW(2), .VBP(1),
    .SYNC_POL(1'b0)
  ) u_sm (
    .pixel_clk (clk),
    .rst       (rst),
    .vif       (sm_if)
  );

  video_timing_gen u_df (
    .pixel_clk (clk),
    .rst       (rst),
    .vif       (df_if)
  );

  obs_t obs_sm;
  obs_t obs_df;
  obs_t q_sm [$];
  obs_t q_df [$];

  assign obs_sm = {sm_if.hpos, sm_if.vpos, sm_if.de, sm_if.hsync,
                   sm_if.vsync, sm_if.fsync, sm_if.pattern};
  assign obs_df = {df_if.hpos, df_if.vpos, df_if.de, df_if.hsync,
                   df_if.vsync, df_if.fsync, df_if.pattern};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic obs_t model(int h, int v, int hres, int hfp,
                                 int hsw, int vres, int vfp, int vsw,
                                 logic pol);
    obs_t o;
    o.h   = 12'(h);
    o.v   = 12'(v);
    o.de  = (h < hres) && (v < vres);
    o.hs  = (h >= hres + hfp && h < hres + hfp + hsw) ? pol : ~pol;
    o.vs  = (v >= vres + vfp && v < vres + vfp + vsw) ? pol : ~pol;
    o.fs  = (h == 0) && (v == vres);
    o.pat = '0;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    if (o.de) o.pat = bars[h / (hres / 8)];
`endif
    return o;
  endfunction

  function automatic obs_t rst_obs(logic pol);
    obs_t o;
    o     = '0;
    o.hs  = ~pol;
    o.vs  = ~pol;
    return o;
  endfunction

  // reference for the small DUT: HTOT 24, VTOT 12
  initial begin
    int h;
    int v;
    h = 0;
    v = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q_sm.push_back(rst_obs(1'b0));
        h = 0;
        v = 0;
      end else begin
        q_sm.push_back(model(h, v, 16, 2, 3, 8, 1, 2, 1'b0));
        h++;
        if (h == 24) begin
          h = 0;
          v++;
          if (v == 12) v = 0;
        end
      end
    end
  end

  // reference for the default DUT: HTOT 1650, VTOT 750
  initial begin
    int h;
    int v;
    h = 0;
    v = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q_df.push_back(rst_obs(1'b1));
        h = 0;
        v = 0;
      end else begin
        q_df.push_back(model(h, v, 1280, 110, 40, 720, 5, 5, 1'b1));
        h++;
        if (h == 1650) begin
          h = 0;
          v++;
          if (v == 750) v = 0;
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (q_sm.size() > 0) chk("sb_sm", obs_sm, q_sm.pop_front());
      if (q_df.size() > 0) chk("sb_df", obs_df, q_df.pop_front());
    end
  end

  initial begin
    int n;
    int fs_cnt;
    int vs_cnt;
    int de_cnt;
    int hs_cnt;
    int hs_first;
    logic [11:0] ph;
    logic [11:0] pv;
    logic [23:0] p0, p160, p1200, p1300;
    logic [23:0] e0, e160, e1200;
    checks = 0;
    errors = 0;
    p0 = '0; p160 = '0; p1200 = '0; p1300 = '1;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    e0 = 24'hFFFFFF; e160 = 24'hFFFF00; e1200 = 24'h000000;
`else
    e0 = 24'h0; e160 = 24'h0; e1200 = 24'h0;
`endif

    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_hsync_sm", sm_if.hsync, 1);
    chk("rst_hsync_df", df_if.hsync, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_de", sm_if.de, 1);
    chk("first_pos", {sm_if.hpos, sm_if.vpos}, 0);
    chk("first_de_df", df_if.de, 1);

    n = 0;
    while (!sm_if.fsync && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("fsync_lat", n, 192);
    chk("fsync_pos", {sm_if.hpos, sm_if.vpos}, {12'd0, 12'd8});

    fs_cnt = 0;
    vs_cnt = 0;
    for (int i = 1; i <= 288; i++) begin
      ph = sm_if.hpos;
      pv = sm_if.vpos;
      @(negedge clk);
      if (i < 288 && sm_if.fsync) fs_cnt++;
      if (!sm_if.vsync) vs_cnt++;
      if (ph == 12'd23 && pv == 12'd11)
        chk("frame_wrap", {sm_if.hpos, sm_if.vpos}, 0);
    end
    chk("frame_len", sm_if.fsync, 1);
    chk("fsync_once", fs_cnt, 0);
    chk("vsync_cycles", vs_cnt, 48);

    n = 0;
    while (!(df_if.hpos == 0 && df_if.vpos == 1) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    de_cnt = 0;
    hs_cnt = 0;
    hs_first = -1;
    for (int i = 0; i < 1650; i++) begin
      if (df_if.de) de_cnt++;
      if (df_if.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(df_if.hpos);
      end
      if (df_if.hpos == 0)    p0    = df_if.pattern;
      if (df_if.hpos == 160)  p160  = df_if.pattern;
      if (df_if.hpos == 1200) p1200 = df_if.pattern;
      if (df_if.hpos == 1300) p1300 = df_if.pattern;
      @(negedge clk);
    end
    chk("line_len", {df_if.hpos, df_if.vpos}, {12'd0, 12'd2});
    chk("line_de", de_cnt, 1280);
    chk("line_hs_cnt", hs_cnt, 40);
    chk("line_hs_start", hs_first, 1390);
    chk("pat_0", p0, e0);
    chk("pat_160", p160, e160);
    chk("pat_1200", p1200, e1200);
    chk("pat_blank", p1300, 0);

    n = 0;
    while (!(sm_if.hpos == 10 && sm_if.vpos == 5) && n < 400) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_de", sm_if.de, 0);
    chk("mid_rst_pos", {sm_if.hpos, sm_if.vpos}, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_vs", sm_if.vsync, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_pos", {sm_if.hpos, sm_if.vpos}, 0);
    chk("restart_de", sm_if.de, 1);
    n = 0;
    while (!sm_if.fsync && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("restart_fsync", n, 192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
